// File: rtl/bandit_scheduler.sv
// Purpose: time-shares one bandit core among CLIENTS environment clients, one
//   action/reward episode at a time, granted round-robin.
// Latency: minimum 4 cycles per episode (IDLE, ACTION, REWARD, SEND); a silent
//   client is cut off after TIMEOUT REWARD cycles and TIMEOUT_REWARD is sent.
// Backpressure: valid/ready on every leg; action handshake is passed through
//   combinationally; captured reward is held stable until reward_ready.
// Ports:
//   clock, reset                 - rising-edge clock, async active-high reset
//   client_request/grant         - per-client request, registered one-hot grant
//   client_action_*              - action forwarded to the granted client
//   client_reward_*              - reward returned by the granted client
//   action_* / reward_*          - bandit core side
//   episode_count/timeout_count  - completed (wrapping) / timed-out (saturating)
module bandit_scheduler #(
  parameter int               CLIENTS        = 4,
  parameter int               TIMEOUT        = 255,
  parameter logic signed [7:0] TIMEOUT_REWARD = 8'sd0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CLIENTS-1:0]     client_request,
  output logic [CLIENTS-1:0]     client_grant,
  output logic [CLIENTS-1:0]     client_action_valid,
  output logic [7:0]             client_action_data,
  input  logic [CLIENTS-1:0]     client_action_ready,
  input  logic [CLIENTS-1:0]     client_reward_valid,
  input  logic [8*CLIENTS-1:0]   client_reward_data,
  output logic [CLIENTS-1:0]     client_reward_ready,
  input  logic                   action_valid,
  input  logic [7:0]             action_data,
  output logic                   action_ready,
  output logic                   reward_valid,
  output logic [7:0]             reward_data,
  input  logic                   reward_ready,
  output logic [15:0]            episode_count,
  output logic [15:0]            timeout_count
);

  localparam int IW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTION = 2'd1,
    REWARD = 2'd2,
    SEND   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic [15:0]     wait_cnt;
  logic [7:0]      reward_reg;

  logic            granted_reward_valid;
  logic [7:0]      granted_reward_data;
  logic            granted_action_ready;
  logic            action_fire;
  logic            timeout_hit;
  logic [2*CLIENTS-1:0] req_twice;

  // Two copies of the request vector let the search start at ptr and walk
  // forward without an explicit wrap; the first hit is the winner.
  assign req_twice = {client_request, client_request};

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      if (!pick_found && req_twice[int'(ptr) + k]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(ptr) + k) % CLIENTS);
      end
    end
  end

  assign granted_reward_valid = client_reward_valid[grant_idx];
  assign granted_reward_data  = client_reward_data[8*grant_idx +: 8];
  assign granted_action_ready = client_action_ready[grant_idx];
  assign action_fire          = action_valid && granted_action_ready;
  // wait_cnt counts REWARD cycles already spent silent, so the TIMEOUT-th
  // cycle is the one where it reads TIMEOUT-1.
  assign timeout_hit          = (wait_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    client_action_valid = '0;
    client_action_data  = '0;
    action_ready        = 1'b0;
    client_reward_ready = '0;
    reward_valid        = 1'b0;
    reward_data         = '0;
    case (state)
      IDLE: begin
        if (pick_found) state_nxt = ACTION;
      end
      ACTION: begin
        // client_grant is one-hot, so it doubles as the valid steering mask.
        client_action_valid = action_valid ? client_grant : '0;
        client_action_data  = action_data;
        action_ready        = granted_action_ready;
        if (action_fire) state_nxt = REWARD;
      end
      REWARD: begin
        client_reward_ready = client_grant;
        if (granted_reward_valid || timeout_hit) state_nxt = SEND;
      end
      SEND: begin
        reward_valid = 1'b1;
        reward_data  = reward_reg;
        if (reward_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      client_grant  <= '0;
      grant_idx     <= '0;
      ptr           <= '0;
      wait_cnt      <= '0;
      reward_reg    <= '0;
      episode_count <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx    <= pick_idx;
            client_grant <= {{(CLIENTS-1){1'b0}}, 1'b1} << pick_idx;
          end
        end
        ACTION: begin
          if (action_fire) wait_cnt <= '0;
        end
        REWARD: begin
          // A reward arriving on the timeout cycle still wins.
          if (granted_reward_valid) begin
            reward_reg <= granted_reward_data;
          end else if (timeout_hit) begin
            reward_reg <= TIMEOUT_REWARD;
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        SEND: begin
          if (reward_ready) begin
            episode_count <= episode_count + 16'd1;
            ptr           <= (grant_idx == IW'(CLIENTS - 1)) ? '0 : grant_idx + 1'b1;
            client_grant  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bandit_scheduler.sv
module tb_bandit_scheduler;

  localparam int CLIENTS = 4;
  localparam int TIMEOUT = 255;
  localparam logic [7:0] TO_REW = 8'h00;

  logic                 clock;
  logic                 reset;
  logic [CLIENTS-1:0]   client_request;
  logic [CLIENTS-1:0]   client_grant;
  logic [CLIENTS-1:0]   client_action_valid;
  logic [7:0]           client_action_data;
  logic [CLIENTS-1:0]   client_action_ready;
  logic [CLIENTS-1:0]   client_reward_valid;
  logic [8*CLIENTS-1:0] client_reward_data;
  logic [CLIENTS-1:0]   client_reward_ready;
  logic                 action_valid;
  logic [7:0]           action_data;
  logic                 action_ready;
  logic                 reward_valid;
  logic [7:0]           reward_data;
  logic                 reward_ready;
  logic [15:0]          episode_count;
  logic [15:0]          timeout_count;

  bandit_scheduler #(
    .CLIENTS(CLIENTS),
    .TIMEOUT(TIMEOUT),
    .TIMEOUT_REWARD(8'sh00)
  ) dut (
    .clock(clock),
    .reset(reset),
    .client_request(client_request),
    .client_grant(client_grant),
    .client_action_valid(client_action_valid),
    .client_action_data(client_action_data),
    .client_action_ready(client_action_ready),
    .client_reward_valid(client_reward_valid),
    .client_reward_data(client_reward_data),
    .client_reward_ready(client_reward_ready),
    .action_valid(action_valid),
    .action_data(action_data),
    .action_ready(action_ready),
    .reward_valid(reward_valid),
    .reward_data(reward_data),
    .reward_ready(reward_ready),
    .episode_count(episode_count),
    .timeout_count(timeout_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [CLIENTS-1:0] onehot;
    logic [7:0]         data;
  } act_exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] ep_before;
    logic [15:0] to_after;
  } rew_exp_t;

  act_exp_t act_q[$];
  rew_exp_t rew_q[$];

  int checks = 0;
  int errors = 0;
  bit abort  = 1'b0;

  // Reference model: arbitration pointer and the two counters.
  int ptr_m = 0;
  int ep_m  = 0;
  int to_m  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    abort = 1'b1;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic int model_pick(input logic [CLIENTS-1:0] mask);
    for (int k = 0; k < CLIENTS; k++) begin
      int c;
      c = (ptr_m + k) % CLIENTS;
      if (mask[c]) return c;
    end
    return 0;
  endfunction

  function automatic logic [29:0] all_outs();
    return {client_grant, client_action_valid, client_action_data, client_reward_ready,
            action_ready, reward_valid, reward_data};
  endfunction

  // Monitor: pops the scoreboard whenever a handshake appears on either side.
  initial begin
    act_exp_t ea;
    rew_exp_t er;
    forever begin
      @(negedge clock);
      if (!reset && action_valid && action_ready) begin
        if (act_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL action_unexpected: handshake to %b with nothing expected", client_action_valid);
        end else begin
          ea = act_q.pop_front();
          check("action_client", 32'(client_action_valid), 32'(ea.onehot));
          check("action_data", 32'(client_action_data), 32'(ea.data));
        end
      end
      if (!reset && reward_valid && reward_ready) begin
        if (rew_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL reward_unexpected: reward 0x%0h with nothing expected", reward_data);
        end else begin
          er = rew_q.pop_front();
          check("reward_data", 32'(reward_data), 32'(er.data));
          check("episode_count_at_send", 32'(episode_count), 32'(er.ep_before));
          check("timeout_count_at_send", 32'(timeout_count), 32'(er.to_after));
        end
      end
    end
  end

  task automatic wait_grant();
    int n;
    n = 0;
    while (client_grant == '0 && !abort) begin
      @(posedge clock); #1;
      n++;
      if (n > 8) bound_fail("grant_wait");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    client_request = '1;
    action_valid = 1'b1;
    client_action_ready = '1;
    client_reward_valid = '1;
    reward_ready = 1'b1;
    ptr_m = 0; ep_m = 0; to_m = 0;
    act_q.delete();
    rew_q.delete();
    #1;
    check("reset_outputs_immediate", 32'(all_outs()), 32'd0);
    check("reset_counters_immediate", {episode_count, timeout_count}, 32'd0);
    repeat (2) begin
      @(posedge clock); #1;
      check("reset_outputs_held", 32'(all_outs()), 32'd0);
    end
    client_request = '0;
    action_valid = 1'b0;
    client_action_ready = '0;
    client_reward_valid = '0;
    reward_ready = 1'b0;
    reset = 1'b0;
  endtask

  // One complete episode. rdly >= TIMEOUT means the client stays silent.
  task automatic run_episode(input logic [CLIENTS-1:0] mask, input bit keep,
                             input logic [7:0] act, input logic [7:0] rew_g,
                             input int cready_dly, input int rdly, input int bdly,
                             output int cycles);
    logic [7:0] rw [CLIENTS];
    logic [CLIENTS-1:0] oh;
    logic [7:0] exp_r;
    bit to;
    int g;
    int n;
    cycles = 0;
    if (abort) return;
    g = model_pick(mask);
    for (int c = 0; c < CLIENTS; c++) rw[c] = 8'($urandom);
    rw[g] = rew_g;
    oh = '0;
    oh[g] = 1'b1;
    to = (rdly >= TIMEOUT);
    exp_r = to ? TO_REW : rw[g];
    act_q.push_back('{onehot: oh, data: act});
    if (to && to_m < 65535) to_m++;
    rew_q.push_back('{data: exp_r, ep_before: 16'(ep_m), to_after: 16'(to_m)});
    ep_m = (ep_m + 1) % 65536;
    ptr_m = (g + 1) % CLIENTS;

    client_request = mask;
    action_valid = 1'b1;
    action_data = act;
    client_action_ready = '1;
    for (int c = 0; c < CLIENTS; c++) client_reward_data[8*c +: 8] = rw[c];
    #1;
    check("idle_grant", 32'(client_grant), 32'd0);
    check("idle_action_ready", 32'(action_ready), 32'd0);
    wait_grant();
    if (abort) return;
    cycles = 1;
    if (!keep && $urandom_range(1) == 1) client_request = '0;
    for (int i = 0; i < cready_dly; i++) begin
      client_action_ready = CLIENTS'($urandom) & ~client_grant;
      #1;
      check("action_wait_valid", 32'(client_action_valid), 32'(oh));
      check("action_wait_ready", 32'(action_ready), 32'd0);
      @(posedge clock); #1;
      cycles++;
    end
    client_action_ready = client_grant;
    @(posedge clock); #1;
    cycles++;
    action_valid = 1'b0;
    client_action_ready = '0;

    n = 0;
    while (client_reward_ready != '0 && !abort) begin
      if (n == rdly) client_reward_valid = client_grant;
      else client_reward_valid = CLIENTS'($urandom) & ~client_grant;
      @(posedge clock); #1;
      cycles++;
      n++;
      if (n > TIMEOUT + 4) bound_fail("reward_wait");
    end
    client_reward_valid = '0;
    check("reward_phase_cycles", n, to ? TIMEOUT : rdly + 1);

    for (int i = 0; i < bdly; i++) begin
      check("send_valid_hold", 32'(reward_valid), 32'd1);
      check("send_data_hold", 32'(reward_data), 32'(exp_r));
      @(posedge clock); #1;
      cycles++;
    end
    reward_ready = 1'b1;
    if (!keep) client_request = '0;
    @(posedge clock); #1;
    cycles++;
    reward_ready = 1'b0;
    check("episode_count_after", 32'(episode_count), 32'(ep_m));
    check("grant_cleared", 32'(client_grant), 32'd0);
  endtask

  // Drive an episode into REWARD, then reset in the middle of it.
  task automatic reset_mid_reward(input logic [CLIENTS-1:0] mask);
    logic [CLIENTS-1:0] oh;
    int g;
    if (abort) return;
    g = model_pick(mask);
    oh = '0;
    oh[g] = 1'b1;
    act_q.push_back('{onehot: oh, data: 8'h5A});
    client_request = mask;
    action_valid = 1'b1;
    action_data = 8'h5A;
    #1;
    wait_grant();
    if (abort) return;
    client_action_ready = client_grant;
    @(posedge clock); #1;
    action_valid = 1'b0;
    client_action_ready = '0;
    client_request = '0;
    check("mid_reward_ready", 32'(client_reward_ready), 32'(oh));
    @(posedge clock); #1;
    do_reset();
  endtask

  initial begin
    int cyc;
    int r;
    int rd;
    reset = 1'b1;
    client_request = '0;
    client_action_ready = '0;
    client_reward_valid = '0;
    client_reward_data = '0;
    action_valid = 1'b0;
    action_data = '0;
    reward_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("por_outputs", 32'(all_outs()), 32'd0);
    check("por_counters", {episode_count, timeout_count}, 32'd0);
    reset = 1'b0;

    // Single client, minimum-latency episode.
    run_episode(4'b0001, 1'b0, 8'h40, 8'h03, 0, 0, 0, cyc);
    check("min_latency_cycles", cyc, 4);
    check("single_episode_count", 32'(episode_count), 32'd1);

    // All clients requesting continuously: strict rotation from pointer 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_episode(4'hF, 1'b1, 8'($urandom), 8'($urandom), 0, 0, 0, cyc);
    end
    client_request = '0;
    check("rotation_episode_count", 32'(episode_count), 32'd8);

    // Silent client: full timeout then injected reward.
    run_episode(4'b0100, 1'b0, 8'h11, 8'h55, 0, TIMEOUT + 20, 0, cyc);
    check("timeout_count_one", 32'(timeout_count), 32'd1);
    // Reward on the exact timeout cycle wins.
    run_episode(4'b1000, 1'b0, 8'h22, 8'h7F, 1, TIMEOUT - 1, 0, cyc);
    check("timeout_count_unchanged", 32'(timeout_count), 32'd1);
    // Bandit stalls reward_ready for 10 cycles; negative reward passes through.
    run_episode(4'b0010, 1'b0, 8'h33, 8'h80, 0, 2, 10, cyc);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      rd = (r == 0) ? TIMEOUT + 5 : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 6);
      run_episode(CLIENTS'($urandom_range(1, 15)), 1'($urandom_range(1)), 8'($urandom),
                  8'($urandom), $urandom_range(0, 2), rd, $urandom_range(0, 3), cyc);
    end

    // Leave the pointer at 3 so a stale pointer after reset would pick client 3.
    run_episode(4'b0100, 1'b0, 8'h66, 8'h01, 0, 0, 0, cyc);
    reset_mid_reward(4'b1000);
    run_episode(4'b1010, 1'b0, 8'h77, 8'h02, 0, 0, 0, cyc);
    check("post_reset_episode_count", 32'(episode_count), 32'd1);

    repeat (5) @(posedge clock);
    #1;
    check("action_queue_drained", act_q.size(), 0);
    check("reward_queue_drained", rew_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/bandit_scheduler.md
BANDIT_SCHEDULER -- requirements
Module: bandit_scheduler

Interface
REQ-001 Parameter CLIENTS, default 4: number of environment clients sharing one bandit core, range 2..8.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles to wait for a client reward, range 1..65535.
REQ-003 Parameter TIMEOUT_REWARD, default 0: signed 8-bit reward injected on timeout.
REQ-004 Ports SHALL be:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- client_request  in  CLIENTS  client i wants one action/reward episode
- client_grant  out  CLIENTS  one-hot owner of current episode
- client_action_valid  out  CLIENTS  action offered to granted client
- client_action_data  out  8  action index, shared by all clients
- client_action_ready  in  CLIENTS  client accepts action
- client_reward_valid  in  CLIENTS  client presents reward
- client_reward_data  in  8*CLIENTS  signed reward, client i at bits [8i+7:8i]
- client_reward_ready  out  CLIENTS  scheduler accepts reward
- action_valid  in  1  bandit core offers action
- action_data  in  8  bandit action index
- action_ready  out  1  scheduler accepts bandit action
- reward_valid  out  1  reward offered to bandit core
- reward_data  out  8  signed reward to bandit core
- reward_ready  in  1  bandit core accepts reward
- episode_count  out  16  completed episodes, wraps
- timeout_count  out  16  timed-out episodes, saturates at 65535

Function
REQ-005 FSM states IDLE, ACTION, REWARD, SEND; exactly one active.
REQ-006 IDLE: if any client_request bit set, grant the first set bit at or above round-robin pointer (wrapping); client_grant registered, valid from next cycle, state -> ACTION.
REQ-007 IDLE with no request: client_grant all zero, state stays IDLE.
REQ-008 ACTION: client_action_valid[g] = action_valid, client_action_data = action_data, action_ready = client_action_ready[g], combinational, g = granted index; all other valid bits zero.
REQ-009 ACTION: on action_valid & action_ready, state -> REWARD; timeout counter cleared.
REQ-010 Outside ACTION: action_ready = 0, all client_action_valid = 0.
REQ-011 Deassertion of client_request[g] after grant SHALL NOT abort the episode.
REQ-012 REWARD: client_reward_ready[g] = 1, others 0; on client_reward_valid[g], capture that client's reward_data into register, state -> SEND.
REQ-013 REWARD: timeout counter increments per cycle without reward; on cycle TIMEOUT without reward, capture TIMEOUT_REWARD, increment timeout_count (saturating), state -> SEND.
REQ-014 Reward valid and timeout on same cycle: client reward wins, timeout_count unchanged.
REQ-015 SEND: reward_valid = 1, reward_data = captured register, stable until reward_ready; on reward_valid & reward_ready, increment episode_count (wrap), pointer = (g+1) mod CLIENTS, clear client_grant, state -> IDLE.
REQ-016 Minimum episode latency: 4 cycles from request to return to IDLE (IDLE, ACTION, REWARD, SEND each one cycle).
REQ-017 Reward data passed unmodified, 8-bit two's complement; no arithmetic on reward.

Reset
REQ-018 reset asserted SHALL immediately, independent of clock: state IDLE, client_grant 0, pointer 0, captured reward 0, timeout counter 0, episode_count 0, timeout_count 0.
REQ-019 During and after reset, all valid/ready outputs 0 until FSM leaves IDLE.
REQ-020 Reset mid-episode (any state) SHALL abandon episode with no reward delivered to bandit and no counter increment.
REQ-021 First grant after reset deassertion SHALL occur no earlier than first rising edge with reset low.

Verification
REQ-022 Single client 0 requests, bandit action 0x40, client rewards 0x03 -> client 0 gets 0x40, bandit gets reward_data 0x03, episode_count 1.
REQ-023 All 4 clients request continuously, 8 episodes -> grant order 0,1,2,3,0,1,2,3; episode_count 8.
REQ-024 Client never returns reward, TIMEOUT 255 -> after 255 REWARD cycles bandit gets 0x00, timeout_count 1.
REQ-025 Reward valid on exact timeout cycle with data 0x7F -> bandit gets 0x7F, timeout_count 0.
REQ-026 Bandit holds reward_ready low 10 cycles -> reward_valid and reward_data stable 10 cycles, then episode completes.
REQ-027 Reset asserted in REWARD -> next cycle all outputs 0, counters 0, client 1 request then granted first (pointer 0 has no request).
